vector_output_serializer: RTL and testbench

Downstream consumer of the CPU's vector output port (`out`, `outFlag`). Captures each flagged VECTOR_SIZE×DATA_WIDTH result word into a small FIFO. Streams the captured words out one DATA_WIDTH element per beat over a valid/ready handshake, so a narrow external sink (host link, display, log port) can drain results without stalling the pipeline.

---
 rtl/vector_output_pkg.sv | 18 +
 rtl/vector_output_serializer_if.sv | 29 ++
 rtl/vector_word_fifo.sv | 51 +++++
 rtl/vector_output_serializer.sv | 111 +++++++++++
 tb/tb_vector_output_serializer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/vector_output_pkg.sv
// Shared constants and state type for the vector output serializer and the CPU top.
package vector_output_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 19;
  localparam int DEFAULT_VECTOR_SIZE = 6;
  localparam int DEFAULT_FIFO_DEPTH  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Index counter width; a one-element word still needs a one-bit index port.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_output_serializer_if.sv
// Element stream from the serializer to a narrow sink (valid/ready handshake).
interface vector_output_serializer_if
  import vector_output_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int INDEX_W    = index_width(DEFAULT_VECTOR_SIZE)
);
  logic [DATA_WIDTH-1:0] elementData;
  logic                  elementValid;
  logic                  elementReady;
  logic [INDEX_W-1:0]    elementIndex;
  logic                  lastElement;

  modport master (
    output elementData,
    output elementValid,
    output elementIndex,
    output lastElement,
    input  elementReady
  );

  modport slave (
    input  elementData,
    input  elementValid,
    input  elementIndex,
    input  lastElement,
    output elementReady
  );
endinterface

// File: rtl/vector_word_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module vector_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok, push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_reg;
  // Head is read combinationally so the consumer can load it on the popping edge.
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/vector_output_serializer.sv
// Captures flagged CPU vector words into a FIFO and streams them out one element per beat.
module vector_output_serializer
  import vector_output_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int VECTOR_SIZE = DEFAULT_VECTOR_SIZE,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] out,
  input  logic                              outFlag,
  vector_output_serializer_if.master        element,
  output logic [$clog2(FIFO_DEPTH):0]       fifoCount,
  output logic                              overflow,
  input  logic                              clearOverflow,
  output logic                              busy
);
  localparam int WORD_W = VECTOR_SIZE * DATA_WIDTH;
  localparam int IDX_W  = index_width(VECTOR_SIZE);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic              overflow_reg, overflow_next;

  logic              fifo_pop, fifo_full, fifo_empty, last_index, drop;
  logic [WORD_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  vector_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (outFlag),
    .push_data (out),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign last_index = (index_reg == IDX_W'(VECTOR_SIZE - 1));
  assign drop       = outFlag & fifo_full & ~fifo_pop;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    index_next    = index_reg;
    fifo_pop      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          shift_next = fifo_head;
          index_next = '0;
          fifo_pop   = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (element.elementReady) begin
          if (!last_index) begin
            shift_next = shift_reg >> DATA_WIDTH;
            index_next = index_reg + 1'b1;
          end else if (!fifo_empty) begin
            // Reload on the last accepted beat so consecutive words have no bubble.
            shift_next = fifo_head;
            index_next = '0;
            fifo_pop   = 1'b1;
          end else begin
            shift_next = '0;
            index_next = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A drop on the same edge as a clear leaves the flag set.
    overflow_next = overflow_reg;
    if (drop)               overflow_next = 1'b1;
    else if (clearOverflow) overflow_next = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      index_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      index_reg    <= index_next;
      overflow_reg <= overflow_next;
    end
  end

  assign element.elementValid = (state_reg == STREAM);
  assign element.elementData  = shift_reg[DATA_WIDTH-1:0];
  assign element.elementIndex = index_reg;
  assign element.lastElement  = (state_reg == STREAM) & last_index;
  assign fifoCount            = fifo_count;
  assign overflow             = overflow_reg;
  assign busy                 = (state_reg == STREAM) | (fifo_count != '0);
endmodule

// File: tb/tb_vector_output_serializer.sv
// Directed bench for vector_output_serializer: capture, backpressure, back-to-back, overflow, reset.
module tb_vector_output_serializer;
  localparam int DW = 19;
  localparam int VS = 6;
  localparam int FD = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [VS*DW-1:0] out = '0;
  logic             outFlag = 1'b0;
  logic             clearOverflow = 1'b0;
  logic [2:0]       fifoCount;
  logic             overflow;
  logic             busy;

  int passed = 0;
  int total  = 0;

  vector_output_serializer_if #(.DATA_WIDTH(DW), .INDEX_W(3)) elem_if ();

  vector_output_serializer #(
    .DATA_WIDTH  (DW),
    .VECTOR_SIZE (VS),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .out           (out),
    .outFlag       (outFlag),
    .element       (elem_if.master),
    .fifoCount     (fifoCount),
    .overflow      (overflow),
    .clearOverflow (clearOverflow),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [VS*DW-1:0] word_seq();
    logic [VS*DW-1:0] w;
    for (int k = 0; k < VS; k++) w[k*DW +: DW] = DW'(k + 1);
    return w;
  endfunction

  function automatic logic [VS*DW-1:0] word_all(input logic [DW-1:0] v);
    logic [VS*DW-1:0] w;
    for (int k = 0; k < VS; k++) w[k*DW +: DW] = v;
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    elem_if.elementReady = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    total++; if (elem_if.elementValid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", elem_if.elementValid); else passed++;
    total++; if (elem_if.elementData !== '0) $display("FAIL reset_data: got %0h expected 0", elem_if.elementData); else passed++;
    total++; if (elem_if.lastElement !== 1'b0) $display("FAIL reset_last: got %0b expected 0", elem_if.lastElement); else passed++;
    total++; if (fifoCount !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifoCount); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", overflow); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
    reset = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_single_capture();
    elem_if.elementReady = 1'b1;
    out = word_seq();
    outFlag = 1'b1;
    tick();
    outFlag = 1'b0;
    total++; if (elem_if.elementValid !== 1'b0) $display("FAIL single_latency: valid got %0b expected 0", elem_if.elementValid); else passed++;
    total++; if (fifoCount !== 3'd1) $display("FAIL single_count: got %0d expected 1", fifoCount); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy: got %0b expected 1", busy); else passed++;
    for (int k = 0; k < VS; k++) begin
      tick();
      total++;
      if (elem_if.elementValid !== 1'b1 || elem_if.elementData !== DW'(k + 1) ||
          elem_if.elementIndex !== 3'(k) || elem_if.lastElement !== (k == VS - 1))
        $display("FAIL single_beat%0d: got v=%0b d=%0h i=%0d l=%0b expected v=1 d=%0h i=%0d l=%0b",
                 k, elem_if.elementValid, elem_if.elementData, elem_if.elementIndex,
                 elem_if.lastElement, k + 1, k, (k == VS - 1));
      else passed++;
    end
    tick();
    total++; if (elem_if.elementValid !== 1'b0 || busy !== 1'b0) $display("FAIL single_end: got v=%0b busy=%0b expected 0/0", elem_if.elementValid, busy); else passed++;
    $display("single_capture: done");
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int exp_k = 0;
    int c = 0;
    elem_if.elementReady = 1'b0;
    out = word_seq();
    outFlag = 1'b1;
    tick();
    outFlag = 1'b0;
    tick();
    while (exp_k < VS && c < 40) begin
      total++;
      if (elem_if.elementValid !== 1'b1 || elem_if.elementData !== DW'(exp_k + 1) || elem_if.elementIndex !== 3'(exp_k))
        $display("FAIL backpressure_cycle%0d: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d",
                 c, elem_if.elementValid, elem_if.elementData, elem_if.elementIndex, exp_k + 1, exp_k);
      else passed++;
      elem_if.elementReady = pat[c % 4];
      tick();
      if (pat[c % 4]) exp_k++;
      c++;
    end
    elem_if.elementReady = 1'b0;
    total++; if (elem_if.elementValid !== 1'b0) $display("FAIL backpressure_end: valid got %0b expected 0", elem_if.elementValid); else passed++;
    $display("backpressure: done after %0d cycles", c);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    elem_if.elementReady = 1'b1;
    out = word_all(19'h00001);
    outFlag = 1'b1;
    tick();
    out = word_all(19'h7FFFF);
    tick();
    outFlag = 1'b0;
    for (int i = 0; i < 2 * VS; i++) begin
      exp = (i < VS) ? 19'h00001 : 19'h7FFFF;
      total++;
      if (elem_if.elementValid !== 1'b1 || elem_if.elementData !== exp || elem_if.elementIndex !== 3'(i % VS))
        $display("FAIL b2b_beat%0d: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d",
                 i, elem_if.elementValid, elem_if.elementData, elem_if.elementIndex, exp, i % VS);
      else passed++;
      tick();
    end
    total++; if (elem_if.elementValid !== 1'b0) $display("FAIL b2b_end: valid got %0b expected 0", elem_if.elementValid); else passed++;
    $display("back_to_back: done");
  endtask

  task automatic test_overflow();
    elem_if.elementReady = 1'b0;
    outFlag = 1'b1;
    for (int k = 1; k <= VS; k++) begin
      out = word_all(DW'(k));
      tick();
    end
    outFlag = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL overflow_set: got %0b expected 1", overflow); else passed++;
    total++; if (fifoCount !== 3'd4) $display("FAIL overflow_count: got %0d expected 4", fifoCount); else passed++;
    total++; if (elem_if.elementData !== 19'd1) $display("FAIL overflow_head: got %0h expected 1", elem_if.elementData); else passed++;
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL overflow_clear: got %0b expected 0", overflow); else passed++;
    out = word_all(19'd9);
    outFlag = 1'b1;
    clearOverflow = 1'b1;
    tick();
    outFlag = 1'b0;
    clearOverflow = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL overflow_set_wins: got %0b expected 1", overflow); else passed++;
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL overflow_reclear: got %0b expected 0", overflow); else passed++;
    $display("overflow: done");
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] exp_words [5] = '{19'd2, 19'd3, 19'd4, 19'd5, 19'd7};
    elem_if.elementReady = 1'b1;
    repeat (VS - 1) tick();
    total++; if (elem_if.lastElement !== 1'b1 || elem_if.elementIndex !== 3'd5) $display("FAIL fullpop_last: got l=%0b i=%0d expected 1/5", elem_if.lastElement, elem_if.elementIndex); else passed++;
    out = word_all(19'd7);
    outFlag = 1'b1;
    tick();
    outFlag = 1'b0;
    total++; if (fifoCount !== 3'd4) $display("FAIL fullpop_count: got %0d expected 4", fifoCount); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %0b expected 0", overflow); else passed++;
    for (int b = 0; b < 5 * VS; b++) begin
      total++;
      if (elem_if.elementValid !== 1'b1 || elem_if.elementData !== exp_words[b / VS])
        $display("FAIL fullpop_drain%0d: got v=%0b d=%0h expected v=1 d=%0h",
                 b, elem_if.elementValid, elem_if.elementData, exp_words[b / VS]);
      else passed++;
      tick();
    end
    total++; if (elem_if.elementValid !== 1'b0 || busy !== 1'b0) $display("FAIL fullpop_end: got v=%0b busy=%0b expected 0/0", elem_if.elementValid, busy); else passed++;
    $display("full_pop: done");
  endtask

  task automatic test_reset_mid_stream();
    elem_if.elementReady = 1'b0;
    outFlag = 1'b1;
    for (int k = 0; k < VS; k++) begin
      out = (k == 0) ? word_seq() : word_all(DW'(k + 10));
      tick();
    end
    outFlag = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL midreset_pre_overflow: got %0b expected 1", overflow); else passed++;
    elem_if.elementReady = 1'b1;
    repeat (3) tick();
    total++; if (elem_if.elementData !== 19'd4) $display("FAIL midreset_pre_data: got %0h expected 4", elem_if.elementData); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (elem_if.elementValid !== 1'b0 || busy !== 1'b0 || fifoCount !== 3'd0 || overflow !== 1'b0)
      $display("FAIL midreset_async: got v=%0b busy=%0b cnt=%0d ovf=%0b expected all 0",
               elem_if.elementValid, busy, fifoCount, overflow);
    else passed++;
    #3;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if (elem_if.elementValid !== 1'b0 || busy !== 1'b0)
        $display("FAIL midreset_residual%0d: got v=%0b busy=%0b expected 0/0", c, elem_if.elementValid, busy);
      else passed++;
    end
    $display("reset_mid_stream: done");
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
